// File: rtl/pc_seq_pkg.sv
// Shared constants for the PC sequencer: next-PC source encodings and default sizes.
// No logic lives here.
package pc_seq_pkg;
  localparam int unsigned PC_W_DEF  = 10;
  localparam int unsigned DEPTH_DEF = 8;

  localparam logic [1:0] JM_INC  = 2'b00;
  localparam logic [1:0] JM_ABS  = 2'b01;
  localparam logic [1:0] JM_RET  = 2'b10;
  localparam logic [1:0] JM_SKIP = 2'b11;
endpackage

// File: rtl/return_stack.sv
// LIFO call stack with push/pop/swap; top_o is the pre-edge top (0 when empty), sp updates at the edge.
// Error pulses are combinational single-cycle strobes; no backpressure, illegal ops are dropped.
module return_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] push_dat_i,
  output logic [PC_W-1:0] top_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            ovf_o,
  output logic            unf_o
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SPW = AW + 1;

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [SPW-1:0]  sp_q, sp_d;
  logic [AW-1:0]   top_idx, wr_idx;
  logic            wr_en;

  assign top_idx = sp_q[AW-1:0] - AW'(1);
  assign empty_o = (sp_q == '0);
  assign full_o  = (sp_q == SPW'(DEPTH));
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  always_comb begin
    sp_d   = sp_q;
    wr_en  = 1'b0;
    wr_idx = sp_q[AW-1:0];
    ovf_o  = 1'b0;
    unf_o  = 1'b0;
    if (push_i && pop_i) begin
      // Swap replaces the top in place; on an empty stack it degrades to a push.
      wr_en = 1'b1;
      if (empty_o) begin
        sp_d  = sp_q + SPW'(1);
        unf_o = 1'b1;
      end else begin
        wr_idx = top_idx;
      end
    end else if (push_i) begin
      if (full_o) begin
        ovf_o = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = sp_q + SPW'(1);
      end
    end else if (pop_i) begin
      if (empty_o) unf_o = 1'b1;
      else         sp_d  = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sp_q <= '0;
    else         sp_q <= sp_d;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_idx] <= push_dat_i;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter with next-PC select, call/return stack, return register with pop bypass, sticky errors.
// All outputs registered, updated one edge after the qualifying strobe; no backpressure.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_PCw,
  input  logic            i_jump,
  input  logic [1:0]      i_j_mode,
  input  logic            i_call,
  input  logic            i_return,
  input  logic [PC_W-1:0] i_target,
  input  logic            i_skip_cond,
  input  logic            i_clr_err,
  output logic [PC_W-1:0] o_pc,
  output logic            o_stack_full,
  output logic            o_stack_empty,
  output logic            o_overflow,
  output logic            o_underflow
);
  logic [PC_W-1:0] pc_q, pc_d, ret_q, ret_d;
  logic [PC_W-1:0] pc_inc1, pc_inc2, pop_dat, ret_src;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            ovf_p, unf_p;

  return_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) u_stack (
    .clk_i      (i_clk),
    .rst_ni     (i_rst),
    .push_i     (i_call & i_PCw),
    .pop_i      (i_return),
    .push_dat_i (pc_inc1),
    .top_o      (pop_dat),
    .full_o     (o_stack_full),
    .empty_o    (o_stack_empty),
    .ovf_o      (ovf_p),
    .unf_o      (unf_p)
  );

  always_comb begin
    pc_inc1 = pc_q + PC_W'(1);
    pc_inc2 = pc_q + PC_W'(2);
    // A pop in the same cycle as RET forwards the popped value straight to the PC.
    ret_src = i_return ? pop_dat : ret_q;
    pc_d    = pc_q;
    if (i_PCw) begin
      unique case (i_j_mode)
        JM_INC:  pc_d = pc_inc1;
        JM_ABS:  pc_d = i_jump ? i_target : pc_inc1;
        JM_RET:  pc_d = ret_src;
        JM_SKIP: pc_d = i_skip_cond ? pc_inc2 : pc_inc1;
        default: pc_d = pc_inc1;
      endcase
    end
    ret_d = i_return ? pop_dat : ret_q;
    ovf_d = (ovf_q & ~i_clr_err) | ovf_p;
    unf_d = (unf_q & ~i_clr_err) | unf_p;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc_q  <= '0;
      ret_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ret_q <= ret_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign o_pc        = pc_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: directed vector table, hand-written stack corner sequences, random traffic vs a queue model.
module tb_pc_sequencer;
  localparam int PC_W  = 10;
  localparam int DEPTH = 8;
  localparam int MASK  = (1 << PC_W) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pcw = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0, skip = 1'b0, clr = 1'b0;
  logic [1:0]      jm = 2'b00;
  logic [PC_W-1:0] tgt = '0;
  logic [PC_W-1:0] pc;
  logic            full, empty, ovf, unf;

  int n_chk  = 0;
  int n_fail = 0;

  int m_pc;
  int m_ret;
  int m_q[$];
  bit m_ovf, m_unf;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_PCw(pcw), .i_jump(jump), .i_j_mode(jm),
    .i_call(call), .i_return(ret), .i_target(tgt), .i_skip_cond(skip),
    .i_clr_err(clr), .o_pc(pc), .o_stack_full(full), .o_stack_empty(empty),
    .o_overflow(ovf), .o_underflow(unf)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ret = 0; m_q.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step(input bit p, input bit j, input int mode, input bit c,
                            input bit r, input int t, input bit s, input bit cl);
    int inc1, inc2, popv, npc;
    bit o, u;
    inc1 = (m_pc + 1) & MASK;
    inc2 = (m_pc + 2) & MASK;
    popv = (m_q.size() > 0) ? m_q[$] : 0;
    npc  = m_pc;
    o = 0; u = 0;
    if (p) begin
      case (mode)
        0: npc = inc1;
        1: npc = j ? t : inc1;
        2: npc = r ? popv : m_ret;
        default: npc = s ? inc2 : inc1;
      endcase
    end
    if (c && p && r) begin
      if (m_q.size() > 0) begin
        m_ret = m_q.pop_back();
        m_q.push_back(inc1);
      end else begin
        m_q.push_back(inc1);
        m_ret = 0;
        u = 1;
      end
    end else if (c && p) begin
      if (m_q.size() == DEPTH) o = 1;
      else m_q.push_back(inc1);
    end else if (r) begin
      if (m_q.size() == 0) begin
        m_ret = 0;
        u = 1;
      end else m_ret = m_q.pop_back();
    end
    m_ovf = (cl ? 1'b0 : m_ovf) | o;
    m_unf = (cl ? 1'b0 : m_unf) | u;
    m_pc  = npc;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},    int'(pc),    m_pc);
    chk({tag, ".full"},  int'(full),  int'(m_q.size() == DEPTH));
    chk({tag, ".empty"}, int'(empty), int'(m_q.size() == 0));
    chk({tag, ".ovf"},   int'(ovf),   int'(m_ovf));
    chk({tag, ".unf"},   int'(unf),   int'(m_unf));
  endtask

  // Drives one cycle of strobes, advances the model and checks after the edge.
  task automatic step(input string tag, input bit p, input bit j, input logic [1:0] mode,
                      input bit c, input bit r, input int t, input bit s, input bit cl);
    pcw = p; jump = j; jm = mode; call = c; ret = r; tgt = PC_W'(t); skip = s; clr = cl;
    model_step(p, j, int'(mode), c, r, t, s, cl);
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  typedef struct {
    bit p, j; logic [1:0] mode; bit c, r; int t; bit s;
    int e_pc; bit e_empty;
  } vec_t;
  vec_t tbl[18];

  function automatic vec_t mk(bit p, bit j, logic [1:0] mode, bit c, bit r, int t, bit s,
                              int e_pc, bit e_empty);
    vec_t v;
    v.p = p; v.j = j; v.mode = mode; v.c = c; v.r = r; v.t = t; v.s = s;
    v.e_pc = e_pc; v.e_empty = e_empty;
    return v;
  endfunction

  initial begin
    int addr[9];
    model_reset();
    tbl[0]  = mk(1, 0, 2'b00, 0, 0, 0,     0, 'h001, 1);
    tbl[1]  = mk(1, 0, 2'b00, 0, 0, 0,     0, 'h002, 1);
    tbl[2]  = mk(1, 0, 2'b00, 0, 0, 0,     0, 'h003, 1);
    tbl[3]  = mk(1, 0, 2'b00, 0, 0, 0,     0, 'h004, 1);
    tbl[4]  = mk(1, 0, 2'b00, 0, 0, 0,     0, 'h005, 1);
    tbl[5]  = mk(1, 1, 2'b01, 1, 0, 'h120, 0, 'h120, 0);
    tbl[6]  = mk(0, 0, 2'b00, 0, 1, 0,     0, 'h120, 1);
    tbl[7]  = mk(1, 0, 2'b10, 0, 0, 0,     0, 'h006, 1);
    tbl[8]  = mk(1, 1, 2'b01, 0, 0, 'h010, 0, 'h010, 1);
    tbl[9]  = mk(1, 0, 2'b11, 0, 0, 0,     1, 'h012, 1);
    tbl[10] = mk(1, 1, 2'b01, 0, 0, 'h010, 0, 'h010, 1);
    tbl[11] = mk(1, 0, 2'b11, 0, 0, 0,     0, 'h011, 1);
    tbl[12] = mk(1, 1, 2'b01, 0, 0, 'h3FF, 0, 'h3FF, 1);
    tbl[13] = mk(1, 0, 2'b00, 0, 0, 0,     0, 'h000, 1);
    tbl[14] = mk(1, 0, 2'b01, 0, 0, 'h155, 0, 'h001, 1);
    tbl[15] = mk(0, 1, 2'b01, 1, 0, 'h200, 0, 'h001, 1);
    tbl[16] = mk(1, 1, 2'b01, 0, 0, 'h3FF, 0, 'h3FF, 1);
    tbl[17] = mk(1, 0, 2'b11, 0, 0, 0,     1, 'h001, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.pc", int'(pc), 0);
    chk("reset.empty", int'(empty), 1);
    chk("reset.full", int'(full), 0);
    chk("reset.ovf", int'(ovf), 0);
    chk("reset.unf", int'(unf), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step("tbl", tbl[i].p, tbl[i].j, tbl[i].mode, tbl[i].c, tbl[i].r, tbl[i].t, tbl[i].s, 0);
      chk($sformatf("tbl%0d.pc", i), int'(pc), tbl[i].e_pc);
      chk($sformatf("tbl%0d.empty", i), int'(empty), int'(tbl[i].e_empty));
    end

    // Nine nested calls on an eight-deep stack, then unwind past empty.
    for (int i = 0; i < 9; i++) begin
      addr[i] = (m_pc + 1) & MASK;
      step("nest", 1, 1, 2'b01, 1, 0, 'h100 + i * 'h20, 0, 0);
      if (i == 7) begin
        chk("nest8.full", int'(full), 1);
        chk("nest8.ovf", int'(ovf), 0);
      end
    end
    chk("nest9.ovf", int'(ovf), 1);
    chk("nest9.full", int'(full), 1);
    for (int i = 7; i >= 0; i--) begin
      step("unwA", 0, 0, 2'b00, 0, 1, 0, 0, 0);
      step("unwB", 1, 0, 2'b10, 0, 0, 0, 0, 0);
      chk($sformatf("unwind%0d.pc", i), int'(pc), addr[i]);
    end
    chk("unwound.empty", int'(empty), 1);
    step("pop9A", 0, 0, 2'b00, 0, 1, 0, 0, 0);
    chk("pop9.unf", int'(unf), 1);
    step("pop9B", 1, 0, 2'b10, 0, 0, 0, 0, 0);
    chk("pop9.retzero", int'(pc), 0);
    step("clr", 0, 0, 2'b00, 0, 0, 0, 0, 1);
    chk("clr.ovf", int'(ovf), 0);
    chk("clr.unf", int'(unf), 0);
    step("clrwin", 0, 0, 2'b00, 0, 1, 0, 0, 1);
    chk("clrwin.unf", int'(unf), 1);
    step("clr2", 0, 0, 2'b00, 0, 0, 0, 0, 1);

    // Same-cycle pop and RET: PC takes the popped value through the bypass.
    step("byp0", 1, 1, 2'b01, 0, 0, 'h0AA, 0, 0);
    step("byp1", 1, 1, 2'b01, 1, 0, 'h300, 0, 0);
    step("byp2", 1, 0, 2'b10, 0, 1, 0, 0, 0);
    chk("bypass.pc", int'(pc), 'h0AB);
    chk("bypass.empty", int'(empty), 1);

    // Swap: call and return together keep depth, replace top, load old top.
    step("swp0", 1, 1, 2'b01, 0, 0, 'h050, 0, 0);
    step("swp1", 1, 1, 2'b01, 1, 0, 'h060, 0, 0);
    step("swp2", 1, 1, 2'b01, 1, 1, 'h070, 0, 0);
    chk("swap.empty", int'(empty), 0);
    step("swp3", 1, 0, 2'b10, 0, 0, 0, 0, 0);
    chk("swap.retreg", int'(pc), 'h051);
    step("swp4", 1, 0, 2'b10, 0, 1, 0, 0, 0);
    chk("swap.newtop", int'(pc), 'h061);
    chk("swap.drained", int'(empty), 1);

    // Asynchronous reset between the two phases of a return.
    step("rst0", 0, 0, 2'b00, 0, 1, 0, 0, 0);
    step("rst1", 1, 1, 2'b01, 1, 0, 'h040, 0, 0);
    step("rstA", 0, 0, 2'b00, 0, 1, 0, 0, 0);
    pcw = 1'b1; jm = 2'b10; ret = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.pc", int'(pc), 0);
    chk("arst.empty", int'(empty), 1);
    chk("arst.full", int'(full), 0);
    chk("arst.ovf", int'(ovf), 0);
    chk("arst.unf", int'(unf), 0);
    model_reset();
    pcw = 1'b0; jm = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 800; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, MASK)), 1'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the FRANK6000 core. It holds the PC and selects the next PC from increment, absolute jump, conditional skip or subroutine return. It owns the hardware call/return stack. It is driven directly by the control unit's jump, j_mode, call, return and PCw strobes, and drives the instruction-memory address.

## Interface
- PC_W, 10: program counter / return-address width.
- DEPTH, 8: call-stack entries; power of two, ≥2.

- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_PCw  in  1  PC write enable; PC changes only when high.
- i_jump  in  1  jump qualifier for absolute mode.
- i_j_mode  in  2  next-PC source select (see Operation).
- i_call  in  1  push return address (qualified by i_PCw).
- i_return  in  1  pop stack top into return register.
- i_target  in  PC_W  absolute target from the instruction word.
- i_skip_cond  in  1  skip condition from STATUS, already evaluated.
- i_clr_err  in  1  synchronous clear of sticky error flags.
- o_pc  out  PC_W  current PC, registered.
- o_stack_full  out  1  sp == DEPTH.
- o_stack_empty  out  1  sp == 0.
- o_overflow  out  1  sticky: push attempted while full.
- o_underflow  out  1  sticky: pop attempted while empty.

## Operation
Next-PC when i_PCw=1, selected by i_j_mode:
- 00 INC: PC+1.
- 01 ABS: i_target if i_jump, else PC+1.
- 10 RET: return register value, or the bypassed pop value if i_return is high in the same cycle.
- 11 SKIP: PC+2 if i_skip_cond, else PC+1.

Other PC rules:
- i_PCw=0: PC holds regardless of other inputs.
- Arithmetic is modulo 2^PC_W; PC+1 and PC+2 wrap silently (max → 0 or 1).

Stack operations:
- Push: i_call & i_PCw. Writes PC+1 (current PC, pre-update) at the top; sp+1.
- Pop: i_return (independent of i_PCw). Loads the return register with the top entry; sp−1.
- Call and pop in the same cycle (swap): return register ← top, top ← PC+1, sp unchanged. Legal on a non-empty stack. On an empty stack it behaves as a push plus underflow, and the return register ← 0.
- Push while full: entry dropped, sp unchanged, o_overflow set. The PC still loads normally.
- Pop while empty: return register ← 0, sp unchanged, o_underflow set.

Error flags:
- i_clr_err clears both flags.
- A new error in the same cycle as i_clr_err wins (flag set).

Two-phase return sequence used by the control unit:
- Cycle A: i_return=1, i_PCw=0.
- Cycle B: i_PCw=1, j_mode=10.

## Timing
- Reset (i_rst low, async): o_pc=0, sp=0, return register=0, o_overflow=0, o_underflow=0, o_stack_full=0, o_stack_empty=1. The reset takes effect mid-operation without waiting for a clock edge.
- o_pc updates one edge after the qualifying i_PCw cycle; there is no combinational path from inputs to o_pc.
- The return register is valid one edge after a pop. Same-cycle RET+pop uses the bypass, so PC ← popped value at that edge.
- o_stack_full, o_stack_empty, o_overflow and o_underflow are registered and reflect state after the edge.
- Stack storage needs no reset; only sp and the return register are reset.

## Structure
- Package pc_seq_pkg holds:
  - j_mode constants JM_INC=2'b00, JM_ABS=2'b01, JM_RET=2'b10, JM_SKIP=2'b11;
  - the default PC_W/DEPTH localparams.
- Sub-module return_stack contains:
  - LIFO storage and the sp counter (width clog2(DEPTH)+1);
  - push/pop/swap handling, full/empty outputs, and overflow/underflow pulses.
- pc_sequencer contains the PC register, next-PC mux, return register with bypass, and the sticky flags.

## Test plan
- Reset then 5 cycles of i_PCw=1, j_mode=00 → o_pc 0,1,2,3,4,5; o_stack_empty=1.
- PC=0x005, call: i_PCw=1, j_mode=01, i_jump=1, i_call=1, target 0x120 → o_pc=0x120, stack top=0x006. Then return (cycle A), RET (cycle B) → o_pc=0x006, stack empty.
- SKIP at PC=0x010: i_skip_cond=1 → 0x012; i_skip_cond=0 → 0x011. INC at PC=0x3FF → 0x000. ABS with i_jump=0 → PC+1.
- 9 nested calls with DEPTH=8: o_stack_full after the 8th, o_overflow set on the 9th, sp stays 8. Then 8 returns unwind in LIFO order; a 9th pop sets o_underflow and the return register=0. i_clr_err clears both flags.
- Same-cycle i_return + i_PCw + j_mode=10 with top=0x0AB → o_pc=0x0AB next edge. Swap with call and return together → sp unchanged, top=PC+1, return register=old top.
- Assert i_rst low between cycles A and B of a return → o_pc=0, sp=0, flags cleared immediately, before the next clock edge.
